// File: rtl/axi_llc_refill_r_sink.sv
// Refill data stage: collects one cache line of AXI R beats into data-way write requests,
// then forwards the descriptor with a sticky response/protocol error flag.
module axi_llc_refill_r_sink #(
  parameter int unsigned NumBlocks   = 4,
  parameter int unsigned BlockSize   = 64,
  parameter int unsigned NumWays     = 8,
  parameter int unsigned IndexLength = 8,
  parameter type desc_t = struct packed {
    logic                   refill;
    logic [NumWays-1:0]     way_ind;
    logic [IndexLength-1:0] index;
  },
  parameter type r_chan_t = struct packed {
    logic [BlockSize-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  },
  localparam int unsigned BeatWidth = $clog2(NumBlocks)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  // Descriptor in
  input  desc_t                  desc_i,
  input  logic                   desc_valid_i,
  output logic                   desc_ready_o,
  // Descriptor out
  output desc_t                  desc_o,
  output logic                   desc_valid_o,
  input  logic                   desc_ready_i,
  output logic                   desc_err_o,
  // AXI R
  input  r_chan_t                r_chan_i,
  input  logic                   r_valid_i,
  output logic                   r_ready_o,
  // Data-way write
  output logic [NumWays-1:0]     wr_way_o,
  output logic [IndexLength-1:0] wr_index_o,
  output logic [BeatWidth-1:0]   wr_block_o,
  output logic [BlockSize-1:0]   wr_data_o,
  output logic                   wr_valid_o,
  input  logic                   wr_ready_i
);

  typedef enum logic [1:0] {StIdle, StRefill, StDrain, StSend} state_e;

  localparam logic [BeatWidth-1:0] LastBeat = BeatWidth'(NumBlocks - 1);

  state_e                 state_q, state_d;
  desc_t                  desc_q, desc_d;
  logic                   err_q, err_d;
  logic [BeatWidth-1:0]   beat_q, beat_d;
  logic                   wr_valid_q, wr_valid_d;
  logic [BeatWidth-1:0]   wr_block_q, wr_block_d;
  logic [BlockSize-1:0]   wr_data_q, wr_data_d;
  logic                   r_ready;
  logic                   r_hs;
  logic                   wr_hs;
  logic                   beat_is_last;
  logic                   unused_resp;

  assign unused_resp  = r_chan_i.resp[0];
  assign wr_hs        = wr_valid_q & wr_ready_i;
  assign r_hs         = r_valid_i & r_ready;
  assign beat_is_last = (beat_q == LastBeat);

  always_comb begin
    state_d    = state_q;
    desc_d     = desc_q;
    err_d      = err_q;
    beat_d     = beat_q;
    wr_valid_d = wr_valid_q;
    wr_block_d = wr_block_q;
    wr_data_d  = wr_data_q;
    r_ready    = 1'b0;

    if (wr_hs) begin
      wr_valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (desc_valid_i) begin
          desc_d  = desc_i;
          state_d = desc_i.refill ? StRefill : StSend;
        end
      end
      StRefill: begin
        // Single-entry write register: accept a beat only if it is empty or draining now.
        r_ready = ~wr_valid_q | wr_ready_i;
        if (r_hs) begin
          wr_valid_d = 1'b1;
          wr_block_d = beat_q;
          wr_data_d  = r_chan_i.data;
          beat_d     = beat_q + 1'b1;
          if (r_chan_i.resp[1] || (r_chan_i.last != beat_is_last)) begin
            err_d = 1'b1;
          end
          // The line length is fixed; a misplaced last never shortens or extends it.
          if (beat_is_last) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (!wr_valid_q || wr_ready_i) begin
          state_d = StSend;
        end
      end
      StSend: begin
        if (desc_ready_i) begin
          state_d = StIdle;
          err_d   = 1'b0;
          beat_d  = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      desc_q     <= '0;
      err_q      <= 1'b0;
      beat_q     <= '0;
      wr_valid_q <= 1'b0;
      wr_block_q <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      desc_q     <= desc_d;
      err_q      <= err_d;
      beat_q     <= beat_d;
      wr_valid_q <= wr_valid_d;
      wr_block_q <= wr_block_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign desc_ready_o = (state_q == StIdle);
  assign desc_valid_o = (state_q == StSend);
  assign desc_err_o   = (state_q == StSend) & err_q;
  assign desc_o       = desc_q;
  assign r_ready_o    = r_ready;

  // Way and index come from the latched descriptor, which is stable for the whole refill.
  assign wr_way_o     = desc_q.way_ind;
  assign wr_index_o   = desc_q.index;
  assign wr_block_o   = wr_block_q;
  assign wr_data_o    = wr_data_q;
  assign wr_valid_o   = wr_valid_q;

endmodule

// File: tb/tb_axi_llc_refill_r_sink.sv
// Self-checking bench for axi_llc_refill_r_sink: directed scenarios plus randomized traffic
// checked against a line-level reference model (expected write list, error flag, latency).
module tb_axi_llc_refill_r_sink;

  localparam int unsigned NumBlocks   = 4;
  localparam int unsigned BlockSize   = 64;
  localparam int unsigned NumWays     = 8;
  localparam int unsigned IndexLength = 8;
  localparam int unsigned BeatWidth   = 2;

  typedef struct packed {
    logic                   refill;
    logic [NumWays-1:0]     way_ind;
    logic [IndexLength-1:0] index;
  } tb_desc_t;

  typedef struct packed {
    logic [BlockSize-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } tb_r_t;

  logic                   clk;
  logic                   rst_i;
  tb_desc_t               desc_i;
  logic                   desc_valid_i;
  logic                   desc_ready_o;
  tb_desc_t               desc_o;
  logic                   desc_valid_o;
  logic                   desc_ready_i;
  logic                   desc_err_o;
  tb_r_t                  r_chan_i;
  logic                   r_valid_i;
  logic                   r_ready_o;
  logic [NumWays-1:0]     wr_way_o;
  logic [IndexLength-1:0] wr_index_o;
  logic [BeatWidth-1:0]   wr_block_o;
  logic [BlockSize-1:0]   wr_data_o;
  logic                   wr_valid_o;
  logic                   wr_ready_i;

  int checks = 0;
  int errors = 0;

  logic [BlockSize-1:0] beat_data[NumBlocks];
  logic [1:0]           beat_resp[NumBlocks];
  logic                 beat_last[NumBlocks];

  axi_llc_refill_r_sink #(
    .NumBlocks  (NumBlocks),
    .BlockSize  (BlockSize),
    .NumWays    (NumWays),
    .IndexLength(IndexLength),
    .desc_t     (tb_desc_t),
    .r_chan_t   (tb_r_t)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .desc_i      (desc_i),
    .desc_valid_i(desc_valid_i),
    .desc_ready_o(desc_ready_o),
    .desc_o      (desc_o),
    .desc_valid_o(desc_valid_o),
    .desc_ready_i(desc_ready_i),
    .desc_err_o  (desc_err_o),
    .r_chan_i    (r_chan_i),
    .r_valid_i   (r_valid_i),
    .r_ready_o   (r_ready_o),
    .wr_way_o    (wr_way_o),
    .wr_index_o  (wr_index_o),
    .wr_block_o  (wr_block_o),
    .wr_data_o   (wr_data_o),
    .wr_valid_o  (wr_valid_o),
    .wr_ready_i  (wr_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic tb_desc_t rand_desc(input logic refill);
    tb_desc_t d;
    d.refill  = refill;
    d.way_ind = NumWays'(1) << $urandom_range(0, NumWays - 1);
    d.index   = IndexLength'($urandom);
    return d;
  endfunction

  // Clean line of random data; optionally inject one response error and/or a misplaced last.
  task automatic fill_beats(input bit inject);
    for (int i = 0; i < NumBlocks; i++) begin
      beat_data[i] = {$urandom, $urandom};
      beat_resp[i] = 2'($urandom_range(0, 1));
      beat_last[i] = (i == NumBlocks - 1);
    end
    if (inject) begin
      if ($urandom_range(0, 2) == 0) beat_resp[$urandom_range(0, NumBlocks - 1)] = 2'b10;
      if ($urandom_range(0, 2) == 0) begin
        int j;
        j = $urandom_range(0, NumBlocks - 1);
        beat_last[j] = ~beat_last[j];
      end
    end
  endtask

  // mode 0: no stalls, exact latency checked; 1: random stalls; 2: wr_ready low cycles 3..5.
  task automatic run_txn(input tb_desc_t d, input int mode);
    logic [BlockSize-1:0] exp_data[$];
    int                   exp_blk[$];
    bit                   exp_err;
    int                   exp_lat;
    int                   rb;
    bit                   done;

    exp_err = 1'b0;
    if (d.refill) begin
      for (int i = 0; i < NumBlocks; i++) begin
        exp_data.push_back(beat_data[i]);
        exp_blk.push_back(i);
        if (beat_resp[i][1]) exp_err = 1'b1;
        if (beat_last[i] != (i == NumBlocks - 1)) exp_err = 1'b1;
      end
      exp_lat = NumBlocks + 2;
    end else begin
      exp_lat = 1;
    end

    desc_i       = d;
    desc_valid_i = 1'b1;
    r_valid_i    = 1'b0;
    wr_ready_i   = 1'b1;
    desc_ready_i = 1'b0;
    @(negedge clk);
    checks++;
    if (desc_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL desc_accept: desc_ready_o=%b required 1", desc_ready_o);
    end
    @(posedge clk);
    #1;
    desc_valid_i = 1'b0;
    desc_i       = rand_desc(1'b1);

    rb   = 0;
    done = 1'b0;
    for (int k = 1; k <= 300 && !done; k++) begin
      r_valid_i = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (rb < NumBlocks) r_chan_i = {beat_data[rb], beat_resp[rb], beat_last[rb]};
      else r_chan_i = {{$urandom, $urandom}, 2'b00, 1'b1};
      case (mode)
        0:       wr_ready_i = 1'b1;
        2:       wr_ready_i = !(k >= 3 && k <= 5);
        default: wr_ready_i = ($urandom_range(0, 2) != 0);
      endcase
      desc_ready_i = (mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      @(negedge clk);

      checks++;
      if (r_ready_o && wr_valid_o && !wr_ready_i) begin
        errors++;
        $display("FAIL r_ready_full: r_ready_o=1 required 0 while write reg stalled (cycle %0d)", k);
      end
      if (!d.refill) begin
        checks++;
        if (r_ready_o !== 1'b0 || wr_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL passthru_idle: r_ready_o=%b wr_valid_o=%b required 0 0",
                   r_ready_o, wr_valid_o);
        end
      end
      if (mode == 0 && d.refill && k == 2) begin
        checks++;
        if (wr_valid_o !== 1'b1) begin
          errors++;
          $display("FAIL wr_latency: wr_valid_o=%b at c2 required 1", wr_valid_o);
        end
      end

      if (r_valid_i && r_ready_o) rb++;

      if (wr_valid_o && wr_ready_i) begin
        checks++;
        if (exp_data.size() == 0) begin
          errors++;
          $display("FAIL wr_extra: unexpected write block=%0d data=%h required none",
                   wr_block_o, wr_data_o);
        end else begin
          if (wr_way_o !== d.way_ind || wr_index_o !== d.index ||
              wr_block_o !== BeatWidth'(exp_blk[0]) || wr_data_o !== exp_data[0]) begin
            errors++;
            $display("FAIL wr_beat: got way=%h idx=%h blk=%0d data=%h required way=%h idx=%h blk=%0d data=%h",
                     wr_way_o, wr_index_o, wr_block_o, wr_data_o,
                     d.way_ind, d.index, exp_blk[0], exp_data[0]);
          end
          void'(exp_data.pop_front());
          void'(exp_blk.pop_front());
        end
      end

      if (desc_valid_o) begin
        if (mode == 0) begin
          checks++;
          if (k != exp_lat) begin
            errors++;
            $display("FAIL desc_latency: desc_valid_o at c%0d required c%0d", k, exp_lat);
          end
        end
        checks++;
        if (desc_o !== d || desc_err_o !== exp_err) begin
          errors++;
          $display("FAIL desc_out: desc=%h err=%b required desc=%h err=%b",
                   desc_o, desc_err_o, d, exp_err);
        end
        checks++;
        if (exp_data.size() != 0 || rb != (d.refill ? NumBlocks : 0)) begin
          errors++;
          $display("FAIL line_count: writes left=%0d r beats=%0d required 0 and %0d",
                   exp_data.size(), rb, d.refill ? NumBlocks : 0);
        end
        if (desc_ready_i) done = 1'b1;
      end
      @(posedge clk);
      #1;
    end

    r_valid_i    = 1'b0;
    desc_ready_i = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL txn_timeout: descriptor not delivered within 300 cycles, required delivery");
    end
    checks++;
    if (desc_valid_o !== 1'b0 || desc_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL back_to_idle: desc_valid_o=%b desc_ready_o=%b required 0 1",
               desc_valid_o, desc_ready_o);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (desc_valid_o !== 1'b0 || desc_err_o !== 1'b0 || r_ready_o !== 1'b0 ||
        wr_valid_o !== 1'b0 || desc_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s: dv=%b err=%b rr=%b wv=%b dr=%b required 0 0 0 0 1",
               name, desc_valid_o, desc_err_o, r_ready_o, wr_valid_o, desc_ready_o);
    end
  endtask

  task automatic test_reset();
    rst_i        = 1'b1;
    desc_i       = '0;
    desc_valid_i = 1'b0;
    desc_ready_i = 1'b0;
    r_chan_i     = '0;
    r_valid_i    = 1'b0;
    wr_ready_i   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_passthrough();
    fill_beats(1'b0);
    run_txn(rand_desc(1'b0), 0);
  endtask

  task automatic test_refill_basic();
    tb_desc_t d;
    for (int i = 0; i < NumBlocks; i++) begin
      beat_data[i] = BlockSize'(8'hA0 + i);
      beat_resp[i] = 2'b00;
      beat_last[i] = (i == NumBlocks - 1);
    end
    d = rand_desc(1'b1);
    run_txn(d, 0);
  endtask

  task automatic test_wr_stall();
    fill_beats(1'b0);
    run_txn(rand_desc(1'b1), 2);
  endtask

  task automatic test_resp_error();
    fill_beats(1'b0);
    beat_resp[2] = 2'b10;
    run_txn(rand_desc(1'b1), 0);
    fill_beats(1'b0);
    run_txn(rand_desc(1'b1), 0);
  endtask

  task automatic test_last_error();
    fill_beats(1'b0);
    beat_last[1] = 1'b1;
    run_txn(rand_desc(1'b1), 0);
    fill_beats(1'b0);
    beat_last[NumBlocks-1] = 1'b0;
    run_txn(rand_desc(1'b1), 1);
  endtask

  task automatic test_reset_mid();
    int rb;
    fill_beats(1'b0);
    desc_i       = rand_desc(1'b1);
    desc_valid_i = 1'b1;
    wr_ready_i   = 1'b1;
    @(posedge clk);
    #1;
    desc_valid_i = 1'b0;
    rb = 0;
    for (int k = 0; k < 20 && rb < 2; k++) begin
      r_valid_i = 1'b1;
      r_chan_i  = {beat_data[rb], beat_resp[rb], beat_last[rb]};
      @(negedge clk);
      if (r_ready_o) rb++;
      @(posedge clk);
      #1;
    end
    r_valid_i = 1'b0;
    rst_i     = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    check_reset_outputs("reset_mid_refill");
    // A fresh line afterwards must start again at block 0.
    fill_beats(1'b0);
    run_txn(rand_desc(1'b1), 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      fill_beats(1'b1);
      run_txn(rand_desc(($urandom_range(0, 3) != 0)), $urandom_range(0, 2));
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 6; n++) begin
      fill_beats(1'b0);
      run_txn(rand_desc(n[0]), 0);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_refill_basic();
    test_wr_stall();
    test_resp_error();
    test_last_error();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
